// File: rtl/result_collector_pkg.sv
// Shared types and widths for the result collector: packer state encoding and
// the result/pair/word widths used across the packer and word FIFO.
package result_collector_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned PAIR_W = 32;
  localparam int unsigned RES_W  = 16;

  typedef enum logic {
    Half0 = 1'b0,
    Half1 = 1'b1
  } pack_state_e;

endpackage

// File: rtl/result_collector_if.sv
// Engine-capture and host-readback signals of the result collector.
// The slave modport is the collector; master is the engine/host side.
interface result_collector_if #(
  parameter int unsigned AW = 3
);
  import result_collector_pkg::*;

  logic              en;
  logic              v_flag;
  logic [RES_W-1:0]  outa;
  logic [RES_W-1:0]  outb;
  logic              flush;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW:0]       word_count;
  logic              full;
  logic              half_flag;
  logic              overflow;
  logic              ovf_clr;

  modport master (
    output en, v_flag, outa, outb, flush, out_ready, ovf_clr,
    input  out_data, out_valid, word_count, full, half_flag, overflow
  );

  modport slave (
    input  en, v_flag, outa, outb, flush, out_ready, ovf_clr,
    output out_data, out_valid, word_count, full, half_flag, overflow
  );

endinterface

// File: rtl/result_collector_word_fifo.sv
// Show-ahead word FIFO: DEPTH x 64-bit storage with occupancy count.
// A push into a full FIFO is still accepted when a pop happens the same cycle.
module result_collector_word_fifo
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  output logic              push_ok,
  input  logic              pop_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              valid,
  output logic              full,
  output logic [AW:0]       count
);

  localparam logic [AW:0] DepthCount = DEPTH[AW:0];

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == DepthCount);
  assign pop     = valid & pop_ready;
  assign push_ok = push & (~full | pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Packs pairs of 16-bit engine results into 64-bit words and queues them for
// host readback; a sticky overflow flag records any word dropped on a full FIFO.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  result_collector_if.slave   bus
);

  pack_state_e       state_q, state_d;
  logic [PAIR_W-1:0] lo_q, lo_d;
  logic              overflow_q, overflow_d;
  logic              capture;
  logic              push_req;
  logic              push_ok;
  logic [WORD_W-1:0] push_word;

  assign capture = bus.en & bus.v_flag;

  // A capture in Half1 takes precedence over a same-cycle flush.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push_req  = 1'b0;
    push_word = {{PAIR_W{1'b0}}, lo_q};
    case (state_q)
      Half0: begin
        if (capture) begin
          lo_d    = {bus.outb, bus.outa};
          state_d = Half1;
        end
      end
      Half1: begin
        if (capture) begin
          push_req  = 1'b1;
          push_word = {bus.outb, bus.outa, lo_q};
          state_d   = Half0;
        end else if (bus.flush) begin
          push_req  = 1'b1;
          push_word = {{PAIR_W{1'b0}}, lo_q};
          state_d   = Half0;
        end
      end
      default: state_d = Half0;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= Half0;
      lo_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      overflow_q <= overflow_d;
    end
  end

  result_collector_word_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_word_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_word),
    .push_ok   (push_ok),
    .pop_ready (bus.out_ready),
    .rd_data   (bus.out_data),
    .valid     (bus.out_valid),
    .full      (bus.full),
    .count     (bus.word_count)
  );

  assign bus.half_flag = (state_q == Half1);
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/overflow, full push+pop and async reset.
module tb_result_collector;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  result_collector_if #(.AW(3)) bus ();

  result_collector #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, v, fl, rdy, clr;
    logic [15:0] a, b;
    logic        e_valid, e_half, e_full, e_ovf;
    logic [3:0]  e_cnt;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic en, input logic v, input logic fl, input logic rdy,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic e_valid, input logic e_half, input logic [3:0] e_cnt,
                              input logic [63:0] e_data);
    vec_t r;
    r.en = en; r.v = v; r.fl = fl; r.rdy = rdy; r.clr = 1'b0;
    r.a = a; r.b = b;
    r.e_valid = e_valid; r.e_half = e_half; r.e_full = 1'b0; r.e_ovf = 1'b0;
    r.e_cnt = e_cnt; r.e_data = e_data;
    return r;
  endfunction

  function automatic logic [63:0] fill_word(input int i);
    return {16'(4 * i + 3), 16'(4 * i + 2), 16'(4 * i + 1), 16'(4 * i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.en = 1'b1; bus.v_flag = 1'b0; bus.flush = 1'b0;
    bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    bus.outa = '0; bus.outb = '0;
  endtask

  task automatic cap(input logic [15:0] a, input logic [15:0] b);
    bus.en = 1'b1; bus.v_flag = 1'b1; bus.outa = a; bus.outb = b;
    tick();
    bus.v_flag = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [63:0] exp);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    set_idle();
    bus.en = 1'b0;
    #3;
    check("reset_cnt", 64'(bus.word_count), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_half", 64'(bus.half_flag), 64'd0);
    check("reset_data", bus.out_data, 64'd0);
    #9 rst = 1'b1;

    //            en v  fl rdy a         b         valid half cnt data
    tbl[0]  = mk(1, 1, 0, 0, 16'h0001, 16'h0002, 0, 1, 0, 64'h0);
    tbl[1]  = mk(1, 1, 0, 0, 16'h0003, 16'h0004, 1, 0, 1, 64'h0004_0003_0002_0001);
    tbl[2]  = mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 64'h0);
    tbl[3]  = mk(1, 1, 0, 0, 16'hAAAA, 16'hBBBB, 0, 1, 0, 64'h0);
    tbl[4]  = mk(1, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 1, 64'h0000_0000_BBBB_AAAA);
    tbl[5]  = mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 64'h0);
    tbl[6]  = mk(0, 1, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 64'h0);
    tbl[7]  = mk(0, 1, 0, 0, 16'h3333, 16'h4444, 0, 0, 0, 64'h0);
    tbl[8]  = mk(1, 1, 0, 0, 16'h0005, 16'h0006, 0, 1, 0, 64'h0);
    tbl[9]  = mk(0, 1, 0, 0, 16'hDEAD, 16'hBEEF, 0, 1, 0, 64'h0);
    tbl[10] = mk(1, 1, 0, 0, 16'h0007, 16'h0008, 1, 0, 1, 64'h0008_0007_0006_0005);
    tbl[11] = mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 64'h0);
    tbl[12] = mk(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 64'h0);
    tbl[13] = mk(1, 1, 0, 0, 16'h0009, 16'h000A, 0, 1, 0, 64'h0);
    tbl[14] = mk(1, 1, 1, 0, 16'h000B, 16'h000C, 1, 0, 1, 64'h000C_000B_000A_0009);
    tbl[15] = mk(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 64'h0);

    for (int i = 0; i < 16; i++) begin
      bus.en = tbl[i].en; bus.v_flag = tbl[i].v; bus.flush = tbl[i].fl;
      bus.out_ready = tbl[i].rdy; bus.ovf_clr = tbl[i].clr;
      bus.outa = tbl[i].a; bus.outb = tbl[i].b;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d_half", i), 64'(bus.half_flag), 64'(tbl[i].e_half));
      check($sformatf("vec%0d_cnt", i), 64'(bus.word_count), 64'(tbl[i].e_cnt));
      check($sformatf("vec%0d_full", i), 64'(bus.full), 64'(tbl[i].e_full));
      check($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_data", i), bus.out_data, tbl[i].e_data);
      end
    end
    set_idle();

    // Fill to full, then overflow; the rejected push also carries ovf_clr.
    for (int j = 0; j < 16; j++) cap(16'(2 * j), 16'(2 * j + 1));
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_cnt", 64'(bus.word_count), 64'd8);
    check("fill_ovf", 64'(bus.overflow), 64'd0);
    cap(16'hFFFF, 16'hFFFF);
    check("ovf_half", 64'(bus.half_flag), 64'd1);
    bus.ovf_clr = 1'b1;
    cap(16'hEEEE, 16'hEEEE);
    bus.ovf_clr = 1'b0;
    check("ovf_set", 64'(bus.overflow), 64'd1);
    check("ovf_cnt", 64'(bus.word_count), 64'd8);
    check("ovf_half0", 64'(bus.half_flag), 64'd0);
    for (int i = 0; i < 8; i++) drain_check($sformatf("drain%0d", i), fill_word(i));
    check("drained_cnt", 64'(bus.word_count), 64'd0);
    check("drained_valid", 64'(bus.out_valid), 64'd0);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);

    // Full FIFO: completing push in the same cycle as a pop is accepted.
    for (int j = 0; j < 16; j++) cap(16'(2 * j), 16'(2 * j + 1));
    cap(16'h1234, 16'h5678);
    bus.out_ready = 1'b1;
    cap(16'h9ABC, 16'hDEF0);
    bus.out_ready = 1'b0;
    check("pp_cnt", 64'(bus.word_count), 64'd8);
    check("pp_ovf", 64'(bus.overflow), 64'd0);
    check("pp_full", 64'(bus.full), 64'd1);
    for (int i = 1; i < 8; i++) drain_check($sformatf("pp_drain%0d", i), fill_word(i));
    drain_check("pp_new", 64'hDEF0_9ABC_5678_1234);
    check("pp_empty", 64'(bus.word_count), 64'd0);

    // Asynchronous reset between edges with words buffered and a half pending.
    for (int j = 0; j < 7; j++) cap(16'(16'h100 + j), 16'(16'h200 + j));
    check("pre_rst_cnt", 64'(bus.word_count), 64'd3);
    check("pre_rst_half", 64'(bus.half_flag), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_cnt", 64'(bus.word_count), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_half", 64'(bus.half_flag), 64'd0);
    check("arst_full", 64'(bus.full), 64'd0);
    check("arst_data", bus.out_data, 64'd0);
    #2 rst = 1'b1;
    cap(16'h0011, 16'h0022);
    check("post_rst_half", 64'(bus.half_flag), 64'd1);
    cap(16'h0033, 16'h0044);
    check("post_rst_cnt", 64'(bus.word_count), 64'd1);
    check("post_rst_data", bus.out_data, 64'h0044_0033_0022_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
